// File: rtl/core_pkg.sv
// Shared types for the core's pipeline control.
// Hazard sequencer states and register constants.
package core_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance stats.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count up until all-ones, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipe.
// Load-use bubbles, redirect flushes, dmem freeze.
module pipeline_hazard_controller
  import core_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_mem_dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             pc_sel_redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  hz_state_e       state, state_d;
  logic [TO_W-1:0] wait_cnt, wait_d;
  logic            mem_busy;
  logic            load_use;
  logic            rs1_hit, rs2_hit;
  logic            halt_enter;
  logic            stall_inc;
  logic            flush_inc;

  assign mem_busy = ex_mem_dmem_req & ~dmem_ready;

  assign rs1_hit = id_use_rs1 & (id_rs1 == id_ex_rd);
  assign rs2_hit = id_use_rs2 & (id_rs2 == id_ex_rd);

  assign load_use = id_ex_mem_read
                  & (id_ex_rd != REG_X0)
                  & (rs1_hit | rs2_hit);

  // Pipe enables/flushes, highest priority first.
  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_write    = 1'b1;
    mem_wb_write    = 1'b1;
    pc_sel_redirect = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (state == HALT || mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (ex_redirect) begin
      pc_sel_redirect = 1'b1;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Next state and wait-cycle bookkeeping.
  always_comb begin
    state_d    = state;
    wait_d     = wait_cnt;
    halt_enter = 1'b0;
    unique case (state)
      RUN: begin
        wait_d = '0;
        if (mem_busy) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
          state_d    = HALT;
          halt_enter = 1'b1;
        end else begin
          wait_d = wait_cnt + TO_W'(1);
        end
      end
      HALT: state_d = HALT;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      if (halt_enter) mem_timeout_err <= 1'b1;
    end
  end

  assign stall_inc = rst_n & (state != HALT) & ~pc_write;
  assign flush_inc = pc_sel_redirect;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .value (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller.
// Directed cases plus random traffic vs a model.
module tb_pipeline_hazard_controller;

  localparam int CW   = 3;
  localparam int TO   = 4;
  localparam int TW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] O_RST    = 7'b0011000;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_REDIR  = 7'b1111111;
  localparam logic [6:0] O_LU     = 7'b0001110;
  localparam logic [6:0] O_NORM   = 7'b1100110;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, id_ex_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          id_ex_mem_read, ex_redirect;
  logic          ex_mem_dmem_req, dmem_ready;
  logic          pc_write, if_id_write, if_id_flush;
  logic          id_ex_flush, ex_mem_write, mem_wb_write;
  logic          pc_sel_redirect, mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    got;

  int n_tests = 0;
  int n_fail  = 0;

  int m_stall  = 0;
  int m_flush  = 0;
  int m_streak = 0;
  bit m_halt   = 0;
  bit m_err    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .CNT_W   (CW),
    .TIMEOUT (TO),
    .TO_W    (TW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rd        (id_ex_rd),
    .ex_redirect     (ex_redirect),
    .ex_mem_dmem_req (ex_mem_dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .pc_sel_redirect (pc_sel_redirect),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_timeout_err (mem_timeout_err)
  );

  assign got = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                ex_mem_write, mem_wb_write, pc_sel_redirect};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Reference: outputs from rule priority; counters as plain integers.
  always @(negedge clk) begin
    logic [6:0] e;
    bit busy, lu;
    if (!rst_n) begin
      m_stall = 0; m_flush = 0; m_streak = 0;
      m_halt = 0; m_err = 0;
    end
    busy = ex_mem_dmem_req && !dmem_ready;
    lu = id_ex_mem_read && id_ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == id_ex_rd) ||
          (id_use_rs2 && id_rs2 == id_ex_rd));
    if (!rst_n)           e = O_RST;
    else if (m_halt)      e = O_FREEZE;
    else if (busy)        e = O_FREEZE;
    else if (ex_redirect) e = O_REDIR;
    else if (lu)          e = O_LU;
    else                  e = O_NORM;
    chk("model_outs", got, e);
    chk("model_stall", stall_cnt, sat(m_stall));
    chk("model_flush", flush_cnt, sat(m_flush));
    chk("model_err", mem_timeout_err, m_err);
    if (rst_n && !m_halt) begin
      if (!e[6]) m_stall++;
      if (!busy && ex_redirect) m_flush++;
      m_streak = busy ? m_streak + 1 : 0;
      if (m_streak == TO + 1) begin
        m_halt = 1;
        m_err  = 1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_ex_rd = 5'd3;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_ex_mem_read = 1'b0; ex_redirect = 1'b0;
    ex_mem_dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outs", got, O_RST);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_err", mem_timeout_err, 0);
    nxt();
    rst_n = 1'b1;

    // Load-use: one bubble, then normal.
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    @(negedge clk);
    chk("t1_bubble", got, O_LU);
    nxt();
    id_ex_mem_read = 1'b0;
    @(negedge clk);
    chk("t1_resume", got, O_NORM);
    chk("t1_stall_cnt", stall_cnt, 1);
    nxt();

    // Load to x0 never stalls.
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0;
    id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    @(negedge clk);
    chk("t2_no_stall", got, O_NORM);
    nxt();
    idle();
    @(negedge clk);
    chk("t2_stall_cnt", stall_cnt, 0);
    nxt();

    // Redirect wins over load-use.
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7;
    id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    ex_redirect = 1'b1;
    @(negedge clk);
    chk("t3_redirect", got, O_REDIR);
    nxt();
    idle();
    @(negedge clk);
    chk("t3_flush_cnt", flush_cnt, 1);
    chk("t3_stall_cnt", stall_cnt, 0);
    nxt();

    // Three dmem wait cycles, then ready.
    do_reset();
    ex_mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_frozen", got, O_FREEZE);
      nxt();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready", got, O_NORM);
    nxt();
    idle();
    @(negedge clk);
    chk("t4_stall_cnt", stall_cnt, 3);
    nxt();

    // Timeout into HALT, then async reset.
    do_reset();
    ex_mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO + 1; i++) nxt();
    @(negedge clk);
    chk("t5_err", mem_timeout_err, 1);
    chk("t5_halt_outs", got, O_FREEZE);
    nxt();
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("t5_halt_hold", got, O_FREEZE);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_err_clr", mem_timeout_err, 0);
    chk("t5_rst_outs", got, O_RST);
    @(negedge clk);
    nxt();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("t5_run", got, O_NORM);
    nxt();

    // Stall counter saturation and mid-stall reset.
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd9;
    id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    for (int i = 0; i < 9; i++) nxt();
    @(negedge clk);
    chk("t6_sat", stall_cnt, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", stall_cnt, 0);
    @(negedge clk);
    nxt();
    rst_n = 1'b1;
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n           = ($urandom_range(0, 119) != 0);
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      id_ex_rd        = 5'($urandom_range(0, 7));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      id_ex_mem_read  = 1'($urandom_range(0, 1));
      ex_redirect     = ($urandom_range(0, 3) == 0);
      ex_mem_dmem_req = ($urandom_range(0, 9) < 5);
      dmem_ready      = ($urandom_range(0, 9) < 5);
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
